// File: rtl/test_adder.sv
// 16-bit carry-lookahead add-with-carry with a registered result/status stage.
// Define TEST_ADDER_FLAGS_EN to build the ovf_q/zero_q flag logic; otherwise both are tied to 0.
module test_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        cin,
  output logic [15:0] out,
  output logic        cout,
  output logic [15:0] sum_q,
  output logic        cout_q,
  output logic        ovf_q,
  output logic        zero_q,
  output logic        valid_q
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = in0 & in1;
  assign p = in0 ^ in1;

  // First level: each 4-bit group derives its internal carries from its group carry-in.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;

    assign c[B]     = grp_c[k];
    assign c[B + 1] = g[B] | (p[B] & grp_c[k]);
    assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & grp_c[k]);
    assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                    | (p[B + 2] & p[B + 1] & p[B] & grp_c[k]);

    assign grp_g[k] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                    | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
    assign grp_p[k] = p[B + 3] & p[B + 2] & p[B + 1] & p[B];
  end

  // Second level: group carries c4/c8/c12/c16 straight from cin.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign out  = p ^ c;
  assign cout = grp_c[4];

  // Free-running sample stage: no enable, no handshake, captures every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= 16'h0000;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= out;
      cout_q  <= cout;
      valid_q <= 1'b1;
    end
  end

`ifdef TEST_ADDER_FLAGS_EN
  logic ovf;

  assign ovf = (in0[15] == in1[15]) && (out[15] != in0[15]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf;
      zero_q <= (out == 16'h0000);
    end
  end
`else
  assign ovf_q  = 1'b0;
  assign zero_q = 1'b0;
`endif

endmodule

// File: tb/tb_test_adder.sv
// Self-checking bench for test_adder: directed corner cases plus randomized operands
// checked against an arithmetic reference model and an expected-result queue.
module tb_test_adder;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        cin;
  logic [15:0] out;
  logic        cout;
  logic [15:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        zero_q;
  logic        valid_q;

  int n_cmp;
  int n_bad;

  // {zero, ovf, cout, sum} expected in the register stage after the next edge
  logic [18:0] exp_q[$];

  test_adder dut (
    .clk    (clk),
    .reset  (reset),
    .in0    (in0),
    .in1    (in1),
    .cin    (cin),
    .out    (out),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q),
    .valid_q(valid_q)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [16:0] s;
    int          sv;
    logic        ovf;
    logic        zero;
    s    = 17'(a) + 17'(b) + 17'(c);
    sv   = int'($signed(a)) + int'($signed(b)) + int'(c);
    ovf  = (sv > 32767) || (sv < -32768);
    zero = (s[15:0] == 16'h0000);
`ifndef TEST_ADDER_FLAGS_EN
    ovf  = 1'b0;
    zero = 1'b0;
`endif
    return {zero, ovf, s[16], s[15:0]};
  endfunction

  task automatic check_regs_zero(input string tag);
    check({tag, "_sum_q"},   sum_q,          16'h0000);
    check({tag, "_cout_q"},  16'(cout_q),    16'h0000);
    check({tag, "_ovf_q"},   16'(ovf_q),     16'h0000);
    check({tag, "_zero_q"},  16'(zero_q),    16'h0000);
    check({tag, "_valid_q"}, 16'(valid_q),   16'h0000);
  endtask

  // ---------------- driver ----------------
  // Apply operands while clk is low, check the combinational result, then the registers.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    logic [18:0] e;
    logic [18:0] r;
    @(negedge clk);
    in0 = a;
    in1 = b;
    cin = c;
    #1;
    e = model(a, b, c);
    check({tag, "_out"},  out,        e[15:0]);
    check({tag, "_cout"}, 16'(cout),  16'(e[16]));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    check({tag, "_sum_q"},   sum_q,        r[15:0]);
    check({tag, "_cout_q"},  16'(cout_q),  16'(r[16]));
    check({tag, "_ovf_q"},   16'(ovf_q),   16'(r[17]));
    check({tag, "_zero_q"},  16'(zero_q),  16'(r[18]));
    check({tag, "_valid_q"}, 16'(valid_q), 16'h0001);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner[6];
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};
    if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
    return 16'($urandom());
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clk_en = 1'b0;
    reset  = 1'b1;
    in0    = 16'h0001;
    in1    = 16'h0001;
    cin    = 1'b1;

    // Combinational path with no clock and reset held
    #1;
    check("t1_out",  out,       16'h0003);
    check("t1_cout", 16'(cout), 16'h0000);
    check_regs_zero("reset");
    #5;
    check("t6_out",  out,       16'h0003);
    check("t6_cout", 16'(cout), 16'h0000);

    clk_en = 1'b1;
    #2;
    reset = 1'b0;

    apply("wrap",   16'hFFFF, 16'h0000, 1'b1);
    apply("ovf_p",  16'h7FFF, 16'h0001, 1'b0);
    apply("ovf_n",  16'h8000, 16'h8000, 1'b0);
    apply("ld1234", 16'h1234, 16'h1111, 1'b0);

    // Reset between edges clears the registers only
    #2;
    reset = 1'b1;
    #1;
    check_regs_zero("mid_rst");
    check("mid_rst_out", out, 16'h2345);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sum_q",   sum_q,        16'h2345);
    check("post_rst_valid_q", 16'(valid_q), 16'h0001);

    // Reset coincident with a clock edge: registers stay cleared
    @(posedge clk);
    reset = 1'b1;
    #1;
    check_regs_zero("edge_rst");
    @(negedge clk);
    reset = 1'b0;

    apply("cin_ripple", 16'h0FFF, 16'h0000, 1'b1);
    apply("all_ones",   16'hFFFF, 16'hFFFF, 1'b1);

    for (int i = 0; i < 300; i++) begin
      apply("rand", pick_operand(), pick_operand(), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/test_adder.md
# test_adder

16-bit add-with-carry block: a carry-lookahead combinational adder with a registered result and status stage. Datapath consumers use the combinational `out`/`cout` directly within the same cycle. Pipelined consumers use the registered `*_q` copies and flags, which are clocked by the single system clock and cleared by the asynchronous reset.

## Interface
Parameters: none; width fixed at 16.

- `clk`  input  1  system clock; rising edge active
- `reset`  input  1  asynchronous, active-high reset
- `in0`  input  16  addend A
- `in1`  input  16  addend B
- `cin`  input  1  carry in
- `out`  output  16  combinational sum, `(in0 + in1 + cin) mod 2^16`
- `cout`  output  1  combinational carry out, bit 16 of the 17-bit sum
- `sum_q`  output  16  registered `out`
- `cout_q`  output  1  registered `cout`
- `ovf_q`  output  1  registered two's-complement overflow flag
- `zero_q`  output  1  registered flag: `out == 16'h0000`
- `valid_q`  output  1  high once the registers hold a post-reset sample

## Operation
- Combinational path:
  - Four 4-bit carry-lookahead groups; each produces per-bit generate/propagate plus group G/P.
  - A second-level lookahead unit forms the group carries c4, c8, c12 and c16 from `cin`.
  - Sum bits: `out[i] = p[i] ^ c[i]`.
  - `cout = c16`.
- Result is independent of `clk` and `reset`; `out`/`cout` follow input changes after propagation delay only.
- Arithmetic is unsigned modulo 2^16.
- Signed overflow: `ovf = (in0[15] == in1[15]) && (out[15] != in0[15])`.
- Register stage, updated every rising `clk` edge when `reset` is low:
  - `sum_q <= out`
  - `cout_q <= cout`
  - `ovf_q <= ovf`
  - `zero_q <= (out == 0)`
  - `valid_q <= 1`
- No enable and no handshake; the stage samples every cycle.

## Timing
- `out`/`cout`: zero-cycle latency, purely combinational; settled within one unit delay in simulation.
- Registered outputs: one-cycle latency, valid after the first rising edge following the input change.
- Reset:
  - Asserting `reset` immediately forces `sum_q = 0`, `cout_q = 0`, `ovf_q = 0`, `zero_q = 0` and `valid_q = 0`, without waiting for a clock edge.
  - `out` and `cout` are not affected by reset.
- Reset mid-operation: registers clear at once; the first rising edge after deassertion captures the current inputs and sets `valid_q`.
- Reset and clock edge together: reset wins; registers stay 0.
- Wrap-around: `16'hFFFF + 0 + 1` gives `out = 0`, `cout = 1`.

## Configuration
- Macro `TEST_ADDER_FLAGS_EN`.
- Defined: `ovf_q` and `zero_q` are computed and registered as described above.
- Not defined:
  - `ovf_q` and `zero_q` are tied to 0 and their logic is omitted.
  - The ports remain present.
  - All other behaviour is unchanged.

## Test plan
- `in0 = 1`, `in1 = 1`, `cin = 1` at t = 0, no clock -> `out = 16'h0003`, `cout = 0` within 1 time unit, unchanged at t = 6.
- `16'hFFFF + 16'h0000 + cin 1`, one clock -> `out = 0`, `cout = 1`; then `sum_q = 0`, `cout_q = 1`, `zero_q = 1`, `ovf_q = 0`.
- `16'h7FFF + 16'h0001 + 0`, one clock -> `out = 16'h8000`, `cout = 0`, `ovf_q = 1`, `zero_q = 0`.
- `16'h8000 + 16'h8000 + 0`, one clock -> `out = 0`, `cout = 1`, `ovf_q = 1`, `zero_q = 1`.
- Load `16'h1234 + 16'h1111`, clock (`sum_q = 16'h2345`, `valid_q = 1`), then assert `reset` between edges -> all `*_q` = 0 immediately while `out` stays `16'h2345`; deassert and clock once -> `sum_q = 16'h2345`, `valid_q = 1`.
- Build without `TEST_ADDER_FLAGS_EN`, `16'h7FFF + 1` -> `ovf_q = 0`, `zero_q = 0`, `sum_q = 16'h8000`.
